// File: rtl/ifu_mem_responder.sv
// Instruction-fetch memory responder: in-order request FIFO feeding a fixed-latency
// line store, returning one tagged instruction line per accepted request.
module ifu_mem_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 128,
  parameter int TAG_WIDTH      = 28,
  parameter int MEM_LATENCY    = 4,
  parameter int REQ_FIFO_DEPTH = 4,
  parameter int MEM_LINES      = 256
) (
  input  logic                  Clock,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH-1:0] mem_reqAddrIn,
  input  logic                  mem_reqValidIn,
  output logic                  mem_readyOut,
  output logic [TAG_WIDTH-1:0]  mem_rspTagOut,
  output logic [LINE_WIDTH-1:0] mem_rspInsLineOut,
  output logic                  mem_rspInsLineValidOut,
  input  logic                  load_wrEnIn,
  input  logic [ADDR_WIDTH-1:0] load_wrAddrIn,
  input  logic [LINE_WIDTH-1:0] load_wrLineIn
);

  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int IDX_BITS    = $clog2(MEM_LINES);
  localparam int PTR_BITS    = $clog2(REQ_FIFO_DEPTH);
  localparam int CNT_BITS    = PTR_BITS + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  localparam logic [3:0]          LAT_LOAD  = 4'(MEM_LATENCY - 1);
  localparam logic [CNT_BITS-1:0] FIFO_FULL = CNT_BITS'(REQ_FIFO_DEPTH);

  logic [TAG_WIDTH-1:0]  fifo_tag [REQ_FIFO_DEPTH];
  logic [PTR_BITS-1:0]   wr_ptr;
  logic [PTR_BITS-1:0]   rd_ptr;
  logic [CNT_BITS-1:0]   count;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  logic [1:0]            state;
  logic [3:0]            lat_cnt;
  logic [TAG_WIDTH-1:0]  cur_tag;

  logic [LINE_WIDTH-1:0] store [MEM_LINES];
  logic [TAG_WIDTH-1:0]  req_tag;
  logic [IDX_BITS-1:0]   rd_idx;
  logic [IDX_BITS-1:0]   wr_idx;
  logic                  unused_addr_bits;

  // Only the line-tag part of a request is kept; the store index is its low bits,
  // so higher address bits alias onto the same line.
  assign req_tag          = mem_reqAddrIn[ADDR_WIDTH-1:OFFSET_BITS];
  assign rd_idx           = cur_tag[IDX_BITS-1:0];
  assign wr_idx           = load_wrAddrIn[OFFSET_BITS +: IDX_BITS];
  assign unused_addr_bits = ^{mem_reqAddrIn[OFFSET_BITS-1:0], load_wrAddrIn};

  assign fifo_empty             = (count == '0);
  assign mem_readyOut           = (count < FIFO_FULL);
  assign push                   = mem_reqValidIn && mem_readyOut;
  assign pop                    = !fifo_empty && ((state == S_IDLE) || (state == S_RESPOND));
  assign mem_rspInsLineValidOut = (state == S_RESPOND);

  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_tag[wr_ptr] <= req_tag;
    end
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Capture reads the store before this edge's preload write lands, so a
  // same-index write on the capture edge returns the old line.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state             <= S_IDLE;
      lat_cnt           <= '0;
      cur_tag           <= '0;
      mem_rspTagOut     <= '0;
      mem_rspInsLineOut <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            cur_tag <= fifo_tag[rd_ptr];
            lat_cnt <= LAT_LOAD;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt != 4'd0) begin
            lat_cnt <= lat_cnt - 4'd1;
          end else begin
            mem_rspTagOut     <= cur_tag;
            mem_rspInsLineOut <= store[rd_idx];
            state             <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          if (pop) begin
            cur_tag <= fifo_tag[rd_ptr];
            lat_cnt <= LAT_LOAD;
            state   <= S_WAIT;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Backing store is deliberately not reset so preloaded code survives a reset.
  always_ff @(posedge Clock) begin
    if (load_wrEnIn) begin
      store[wr_idx] <= load_wrLineIn;
    end
  end

endmodule

// File: tb/tb_ifu_mem_responder.sv
// Directed bench for ifu_mem_responder: a scoreboard queue holds the tag, line and
// response cycle expected for each accepted request; a monitor pops it on each strobe.
module tb_ifu_mem_responder;

  localparam int LAT = 4;
  localparam logic [127:0] LINE5     = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] LINE5_NEW = 128'hFEED_FACE_CAFE_BEEF_1357_9BDF_2468_ACE0;

  logic         Clock = 1'b0;
  logic         Rst;
  logic [31:0]  mem_reqAddrIn;
  logic         mem_reqValidIn;
  logic         mem_readyOut;
  logic [27:0]  mem_rspTagOut;
  logic [127:0] mem_rspInsLineOut;
  logic         mem_rspInsLineValidOut;
  logic         load_wrEnIn;
  logic [31:0]  load_wrAddrIn;
  logic [127:0] load_wrLineIn;

  typedef struct {
    logic [27:0]  tag;
    logic [127:0] line;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model_mem [256];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           prev_rsp = -1000;
  int           last_accept = 0;
  int           last_stall = 0;
  int           first_accept = 0;

  ifu_mem_responder dut (
    .Clock                  (Clock),
    .Rst                    (Rst),
    .mem_reqAddrIn          (mem_reqAddrIn),
    .mem_reqValidIn         (mem_reqValidIn),
    .mem_readyOut           (mem_readyOut),
    .mem_rspTagOut          (mem_rspTagOut),
    .mem_rspInsLineOut      (mem_rspInsLineOut),
    .mem_rspInsLineValidOut (mem_rspInsLineValidOut),
    .load_wrEnIn            (load_wrEnIn),
    .load_wrAddrIn          (load_wrAddrIn),
    .load_wrLineIn          (load_wrLineIn)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Drives one request and holds it until accepted; called on a falling edge.
  task automatic applyStimulus(input logic [31:0] addr);
    int   waited = 0;
    exp_t e;
    logic [7:0] idx;
    mem_reqAddrIn  = addr;
    mem_reqValidIn = 1'b1;
    while (mem_readyOut !== 1'b1 && waited < 50) begin
      @(negedge Clock);
      waited++;
    end
    checkOutput("accept_ready", 128'(mem_readyOut), 128'h1);
    if (mem_readyOut !== 1'b1) begin
      mem_reqValidIn = 1'b0;
      return;
    end
    @(posedge Clock);
    @(negedge Clock);
    last_stall  = waited;
    last_accept = cyc;
    idx         = addr[11:4];
    e.tag       = addr[31:4];
    e.line      = model_mem[idx];
    e.cyc       = (last_accept + LAT + 1 > prev_rsp + LAT + 1) ? last_accept + LAT + 1 : prev_rsp + LAT + 1;
    prev_rsp    = e.cyc;
    sb.push_back(e);
    mem_reqValidIn = 1'b0;
  endtask

  task automatic applyPreload(input logic [31:0] addr, input logic [127:0] line);
    logic [7:0] idx;
    load_wrEnIn   = 1'b1;
    load_wrAddrIn = addr;
    load_wrLineIn = line;
    @(negedge Clock);
    load_wrEnIn   = 1'b0;
    idx           = addr[11:4];
    model_mem[idx] = line;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge Clock);
      n++;
    end
    checkOutput("drain", 128'(sb.size()), 128'h0);
    @(negedge Clock);
  endtask

  // Every strobe must match the oldest outstanding request, including its cycle.
  always @(negedge Clock) begin
    exp_t e;
    if (Rst === 1'b1 && mem_rspInsLineValidOut === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_rsp observed=tag %h expected=no response", mem_rspTagOut);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("rsp_tag", 128'(mem_rspTagOut), 128'(e.tag));
        checkOutput("rsp_line", mem_rspInsLineOut, e.line);
        checkOutput("rsp_cycle", 128'(cyc), 128'(e.cyc));
      end
    end
  end

  initial begin
    Rst            = 1'b0;
    mem_reqAddrIn  = '0;
    mem_reqValidIn = 1'b0;
    load_wrEnIn    = 1'b0;
    load_wrAddrIn  = '0;
    load_wrLineIn  = '0;
    repeat (2) @(negedge Clock);

    checkOutput("rst_valid", 128'(mem_rspInsLineValidOut), 128'h0);
    checkOutput("rst_tag", 128'(mem_rspTagOut), 128'h0);
    checkOutput("rst_line", mem_rspInsLineOut, 128'h0);
    Rst = 1'b1;
    @(negedge Clock);
    checkOutput("rst_ready", 128'(mem_readyOut), 128'h1);

    for (int i = 0; i < 5; i++) begin
      applyPreload(32'(i * 16), {32'(i), 32'hC0DE_0000 | 32'(i), ~32'(i), 32'(i * 7 + 3)});
    end
    applyPreload(32'h0000_0050, LINE5);

    // Single request from idle, then the held outputs after the pulse.
    applyStimulus(32'h0000_0050);
    waitDrain();
    checkOutput("pulse_end", 128'(mem_rspInsLineValidOut), 128'h0);
    checkOutput("hold_tag", 128'(mem_rspTagOut), 128'h5);
    checkOutput("hold_line", mem_rspInsLineOut, LINE5);

    // Six back-to-back requests: the FIFO fills and the last one stalls.
    applyStimulus(32'h0000_0000);
    first_accept = last_accept;
    applyStimulus(32'h0000_0010);
    applyStimulus(32'h0000_0020);
    applyStimulus(32'h0000_0030);
    applyStimulus(32'h0000_0040);
    checkOutput("full_ready", 128'(mem_readyOut), 128'h0);
    applyStimulus(32'h0000_0050);
    checkOutput("full_stall", 128'(last_stall), 128'd2);
    checkOutput("full_accept", 128'(last_accept - first_accept), 128'd7);
    waitDrain();

    // Aliased address maps onto line 5 but keeps its own tag.
    applyStimulus(32'h0000_1050);
    waitDrain();
    checkOutput("alias_tag", 128'(mem_rspTagOut), 128'h105);
    checkOutput("alias_line", mem_rspInsLineOut, LINE5);

    // Preload collides with the capture edge: old line first, new line afterwards.
    applyStimulus(32'h0000_0050);
    repeat (4) @(negedge Clock);
    applyPreload(32'h0000_0050, LINE5_NEW);
    waitDrain();
    checkOutput("collide_old", mem_rspInsLineOut, LINE5);
    applyStimulus(32'h0000_0050);
    waitDrain();
    checkOutput("collide_new", mem_rspInsLineOut, LINE5_NEW);

    // Reset while waiting with three requests queued.
    applyStimulus(32'h0000_0000);
    applyStimulus(32'h0000_0010);
    applyStimulus(32'h0000_0020);
    applyStimulus(32'h0000_0030);
    #2;
    Rst = 1'b0;
    sb.delete();
    prev_rsp = -1000;
    #1;
    checkOutput("midrst_valid", 128'(mem_rspInsLineValidOut), 128'h0);
    checkOutput("midrst_tag", 128'(mem_rspTagOut), 128'h0);
    checkOutput("midrst_line", mem_rspInsLineOut, 128'h0);
    repeat (2) @(negedge Clock);
    Rst = 1'b1;
    @(negedge Clock);
    checkOutput("midrst_ready", 128'(mem_readyOut), 128'h1);
    repeat (20) @(negedge Clock);
    checkOutput("midrst_quiet", 128'(mem_rspTagOut), 128'h0);
    applyStimulus(32'h0000_0050);
    waitDrain();
    checkOutput("post_rst_line", mem_rspInsLineOut, LINE5_NEW);

    repeat (3) @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
